// File: rtl/mrv1_dmem_bridge.sv
// MRV1 data-memory bridge: FIFO-buffered core requests, bounded outstanding memory
// requests and local error responses. Optional alignment check: MRV1_DMEM_BRIDGE_ALIGN_CHK_EN.
module mrv1_dmem_bridge #(
  parameter int unsigned               DATA_WIDTH_P = 32,
  parameter int unsigned               REQ_DEPTH_P  = 4,
  parameter int unsigned               MAX_OUTST_P  = 2,
  parameter logic [DATA_WIDTH_P-1:0]   BASE_ADDR_P  = DATA_WIDTH_P'(32'h0000_0000),
  parameter logic [DATA_WIDTH_P-1:0]   SIZE_P       = DATA_WIDTH_P'(32'h0001_0000)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      core_req_vld_i,
  output logic                      core_req_rdy_o,
  input  logic [DATA_WIDTH_P-1:0]   core_req_addr_i,
  input  logic                      core_req_w_en_i,
  input  logic [DATA_WIDTH_P/8-1:0] core_req_w_be_i,
  input  logic [DATA_WIDTH_P-1:0]   core_req_w_data_i,
  output logic                      core_resp_vld_o,
  output logic                      core_resp_err_o,
  output logic [DATA_WIDTH_P-1:0]   core_resp_r_data_o,
  output logic                      mem_req_vld_o,
  input  logic                      mem_req_rdy_i,
  output logic [DATA_WIDTH_P-1:0]   mem_req_addr_o,
  output logic                      mem_req_w_en_o,
  output logic [DATA_WIDTH_P/8-1:0] mem_req_w_be_o,
  output logic [DATA_WIDTH_P-1:0]   mem_req_w_data_o,
  input  logic                      mem_resp_vld_i,
  input  logic [DATA_WIDTH_P-1:0]   mem_resp_r_data_i
);

  localparam int unsigned BE_W  = DATA_WIDTH_P / 8;
  localparam int unsigned PTR_W = $clog2(REQ_DEPTH_P);
  localparam int unsigned OUT_W = $clog2(MAX_OUTST_P + 1);
  // Region bounds carry one extra bit so BASE+SIZE cannot wrap.
  localparam logic [DATA_WIDTH_P:0] RANGE_LO = {1'b0, BASE_ADDR_P};
  localparam logic [DATA_WIDTH_P:0] RANGE_HI = {1'b0, BASE_ADDR_P} + {1'b0, SIZE_P};

  logic [DATA_WIDTH_P-1:0] addr_mem  [REQ_DEPTH_P];
  logic                    w_en_mem  [REQ_DEPTH_P];
  logic [BE_W-1:0]         w_be_mem  [REQ_DEPTH_P];
  logic [DATA_WIDTH_P-1:0] w_data_mem[REQ_DEPTH_P];
  logic                    legal_mem [REQ_DEPTH_P];

  logic [PTR_W:0]          wr_ptr_reg, rd_ptr_reg;
  logic [OUT_W-1:0]        outst_reg;
  logic                    resp_vld_reg, resp_err_reg;
  logic [DATA_WIDTH_P-1:0] resp_data_reg;

  logic empty, full, push, pop, issue, err_pop, resp_take, head_legal;
  logic range_ok, align_ok, req_legal;
  logic [DATA_WIDTH_P:0] addr_ext;
  logic [PTR_W-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx = rd_ptr_reg[PTR_W-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) && (wr_idx == rd_idx);

  assign addr_ext = {1'b0, core_req_addr_i};
  assign range_ok = (addr_ext >= RANGE_LO) && (addr_ext < RANGE_HI);

`ifdef MRV1_DMEM_BRIDGE_ALIGN_CHK_EN
  always_comb begin
    align_ok = 1'b1;
    if (!core_req_w_en_i)
      align_ok = (core_req_addr_i[1:0] == 2'b00);
    else if (core_req_w_be_i == 4'b1111)
      align_ok = (core_req_addr_i[1:0] == 2'b00);
    else if (core_req_w_be_i == 4'b0011 || core_req_w_be_i == 4'b1100)
      align_ok = !core_req_addr_i[0];
    else
      align_ok = ($countones(core_req_w_be_i) == 1);
  end
`else
  assign align_ok = 1'b1;
`endif

  assign req_legal = range_ok && align_ok;

  assign core_req_rdy_o = rst_ni && !full;
  assign push           = core_req_vld_i && core_req_rdy_o;

  assign head_legal       = legal_mem[rd_idx];
  assign mem_req_addr_o   = addr_mem[rd_idx];
  assign mem_req_w_en_o   = w_en_mem[rd_idx];
  assign mem_req_w_be_o   = w_be_mem[rd_idx];
  assign mem_req_w_data_o = w_data_mem[rd_idx];

  assign mem_req_vld_o = !empty && head_legal && (outst_reg < OUT_W'(MAX_OUTST_P));
  assign issue         = mem_req_vld_o && mem_req_rdy_i;
  // Illegal heads retire only once memory is drained, keeping responses in order.
  assign err_pop       = !empty && !head_legal && (outst_reg == '0);
  assign pop           = issue || err_pop;
  assign resp_take     = mem_resp_vld_i && (outst_reg != '0);

  assign core_resp_vld_o    = resp_vld_reg;
  assign core_resp_err_o    = resp_err_reg;
  assign core_resp_r_data_o = resp_data_reg;

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_idx]   <= core_req_addr_i;
      w_en_mem[wr_idx]   <= core_req_w_en_i;
      w_be_mem[wr_idx]   <= core_req_w_be_i;
      w_data_mem[wr_idx] <= core_req_w_data_i;
      legal_mem[wr_idx]  <= req_legal;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      outst_reg     <= '0;
      resp_vld_reg  <= 1'b0;
      resp_err_reg  <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({issue, resp_take})
        2'b10:   outst_reg <= outst_reg + OUT_W'(1);
        2'b01:   outst_reg <= outst_reg - OUT_W'(1);
        default: outst_reg <= outst_reg;
      endcase
      resp_vld_reg  <= resp_take || err_pop;
      resp_err_reg  <= err_pop;
      resp_data_reg <= resp_take ? mem_resp_r_data_i : '0;
    end
  end

endmodule

// File: tb/tb_mrv1_dmem_bridge.sv
// Scoreboard bench for mrv1_dmem_bridge: stimulus queues expected memory requests and
// core responses; two monitors pop and compare whenever the DUT presents them.
module tb_mrv1_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_vld, core_req_rdy, core_req_w_en;
  logic [31:0] core_req_addr, core_req_w_data;
  logic [3:0]  core_req_w_be;
  logic        core_resp_vld, core_resp_err;
  logic [31:0] core_resp_r_data;
  logic        mem_req_vld, mem_req_rdy, mem_req_w_en;
  logic [31:0] mem_req_addr, mem_req_w_data;
  logic [3:0]  mem_req_w_be;
  logic        mem_resp_vld;
  logic [31:0] mem_resp_r_data;

  always #5 clk = ~clk;

  mrv1_dmem_bridge dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_vld_i(core_req_vld), .core_req_rdy_o(core_req_rdy),
    .core_req_addr_i(core_req_addr), .core_req_w_en_i(core_req_w_en),
    .core_req_w_be_i(core_req_w_be), .core_req_w_data_i(core_req_w_data),
    .core_resp_vld_o(core_resp_vld), .core_resp_err_o(core_resp_err),
    .core_resp_r_data_o(core_resp_r_data),
    .mem_req_vld_o(mem_req_vld), .mem_req_rdy_i(mem_req_rdy),
    .mem_req_addr_o(mem_req_addr), .mem_req_w_en_o(mem_req_w_en),
    .mem_req_w_be_o(mem_req_w_be), .mem_req_w_data_o(mem_req_w_data),
    .mem_resp_vld_i(mem_resp_vld), .mem_resp_r_data_i(mem_resp_r_data)
  );

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] data; } mreq_t;
  typedef struct { logic err; logic [31:0] data; } resp_t;

  mreq_t exp_mem[$];
  resp_t exp_resp[$];
  int checks = 0, passes = 0, issue_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon_mem
    mreq_t e;
    if (rst_n && mem_req_vld && mem_req_rdy) begin
      issue_cnt++;
      $display("mem_req  addr=0x%08h we=%0b be=%04b data=0x%08h",
               mem_req_addr, mem_req_w_en, mem_req_w_be, mem_req_w_data);
      if (exp_mem.size() == 0) begin
        checks++;
        $display("FAIL mem_req_unexpected: got addr 0x%08h, expected no request", mem_req_addr);
      end else begin
        e = exp_mem.pop_front();
        chk("mem_req_addr", mem_req_addr, e.addr);
        chk("mem_req_w_en", {31'b0, mem_req_w_en}, {31'b0, e.we});
        chk("mem_req_w_be", {28'b0, mem_req_w_be}, {28'b0, e.be});
        chk("mem_req_w_data", mem_req_w_data, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon_resp
    resp_t e;
    if (core_resp_vld) begin
      $display("core_resp err=%0b data=0x%08h", core_resp_err, core_resp_r_data);
      if (exp_resp.size() == 0) begin
        checks++;
        $display("FAIL core_resp_unexpected: got err=%0b data=0x%08h, expected no response",
                 core_resp_err, core_resp_r_data);
      end else begin
        e = exp_resp.pop_front();
        chk("core_resp_err", {31'b0, core_resp_err}, {31'b0, e.err});
        chk("core_resp_data", core_resp_r_data, e.data);
      end
    end
  end

  // One core request; called and returns at posedge+1.
  task automatic req(input logic [31:0] a, input logic we, input logic [3:0] be,
                     input logic [31:0] d, input logic legal, input logic [31:0] rdata,
                     input logic exp_acc);
    logic acc;
    core_req_vld = 1'b1; core_req_addr = a; core_req_w_en = we;
    core_req_w_be = be; core_req_w_data = d;
    @(negedge clk) acc = core_req_rdy;
    @(posedge clk); #1;
    core_req_vld = 1'b0;
    chk("core_req_rdy", {31'b0, acc}, {31'b0, exp_acc});
    if (acc) begin
      if (legal) begin
        exp_mem.push_back('{addr: a, we: we, be: be, data: d});
        exp_resp.push_back('{err: 1'b0, data: rdata});
      end else begin
        exp_resp.push_back('{err: 1'b1, data: 32'h0});
      end
    end
  endtask

  task automatic respond(input logic [31:0] d);
    mem_resp_vld = 1'b1; mem_resp_r_data = d;
    @(posedge clk); #1;
    mem_resp_vld = 1'b0; mem_resp_r_data = 32'h0;
  endtask

  task automatic wait_issues(input int target, input int budget);
    int n = 0;
    while (issue_cnt < target && n < budget) begin @(posedge clk); #1; n++; end
    chk("issue_count_reached", issue_cnt, target);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_resp.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    chk("responses_pending", exp_resp.size(), 0);
  endtask

  logic [31:0] tbl [4];
  int base;

  initial begin
    tbl[0] = 32'hA1A1_0001; tbl[1] = 32'hB2B2_0002; tbl[2] = 32'hC3C3_0003; tbl[3] = 32'hD4D4_0004;
    rst_n = 1'b0; core_req_vld = 1'b0; core_req_addr = '0; core_req_w_en = 1'b0;
    core_req_w_be = '0; core_req_w_data = '0; mem_req_rdy = 1'b0;
    mem_resp_vld = 1'b0; mem_resp_r_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_req_rdy", {31'b0, core_req_rdy}, 32'd0);
    chk("rst_core_resp_vld", {31'b0, core_resp_vld}, 32'd0);
    chk("rst_core_resp_err", {31'b0, core_resp_err}, 32'd0);
    chk("rst_core_resp_data", core_resp_r_data, 32'd0);
    chk("rst_mem_req_vld", {31'b0, mem_req_vld}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_reset", {31'b0, core_req_rdy}, 32'd1);

    // Single read: issue one cycle after accept, response one cycle after mem_resp.
    mem_req_rdy = 1'b1;
    req(32'h10, 1'b0, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    chk("issue_latency_vld", {31'b0, mem_req_vld}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_resp_vld = 1'b1; mem_resp_r_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("resp_not_early", {31'b0, core_resp_vld}, 32'd0);
    @(posedge clk); #1;
    mem_resp_vld = 1'b0; mem_resp_r_data = 32'h0;
    wait_drain(4);

    // Fill the FIFO with memory stalled; fifth request is refused.
    mem_req_rdy = 1'b0;
    base = issue_cnt;
    req(32'h20, 1'b0, 4'h0,    32'h0,         1'b1, tbl[0], 1'b1);
    req(32'h24, 1'b1, 4'b0101, 32'h1234_5678, 1'b1, tbl[1], 1'b1);
    req(32'h28, 1'b0, 4'h0,    32'h0,         1'b1, tbl[2], 1'b1);
    req(32'h2C, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, tbl[3], 1'b1);
    req(32'h30, 1'b0, 4'h0,    32'h0,         1'b1, 32'h0,  1'b0);
    mem_req_rdy = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("outst_cap_issues", issue_cnt - base, 2);
    chk("outst_cap_vld_low", {31'b0, mem_req_vld}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      respond(tbl[i]);
      repeat (2) begin @(posedge clk); #1; end
    end
    wait_drain(10);
    chk("fill_total_issues", issue_cnt - base, 4);

    // Out-of-range read queued behind two legal reads (upper boundary of region).
    base = issue_cnt;
    req(32'h0000_FFFC, 1'b0, 4'h0, 32'h0, 1'b1, 32'h5555_0001, 1'b1);
    req(32'h0000_0044, 1'b0, 4'h0, 32'h0, 1'b1, 32'h5555_0002, 1'b1);
    req(32'h0001_0000, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,         1'b1);
    wait_issues(base + 2, 10);
    repeat (3) begin @(posedge clk); #1; end
    chk("illegal_head_no_req", {31'b0, mem_req_vld}, 32'd0);
    respond(32'h5555_0001);
    @(posedge clk); #1;
    respond(32'h5555_0002);
    wait_drain(10);
    chk("illegal_no_mem_issue", issue_cnt - base, 2);

    // Reset with two outstanding and a full FIFO.
    base = issue_cnt;
    req(32'h50, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    req(32'h54, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    wait_issues(base + 2, 10);
    for (int i = 0; i < 4; i++)
      req(32'h58 + 32'(4 * i), 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    chk("full_rdy_low", {31'b0, core_req_rdy}, 32'd0);
    #2 rst_n = 1'b0;
    exp_mem.delete();
    exp_resp.delete();
    #1;
    chk("midrst_core_req_rdy", {31'b0, core_req_rdy}, 32'd0);
    chk("midrst_mem_req_vld", {31'b0, mem_req_vld}, 32'd0);
    chk("midrst_core_resp_vld", {31'b0, core_resp_vld}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    respond(32'hBAD0_BAD0);
    repeat (3) begin @(posedge clk); #1; end
    chk("postrst_rdy", {31'b0, core_req_rdy}, 32'd1);
    chk("postrst_mem_req_vld", {31'b0, mem_req_vld}, 32'd0);
    base = issue_cnt;
    req(32'h80, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1);
    wait_issues(base + 1, 10);
    respond(32'h0BAD_F00D);
    wait_drain(5);

`ifdef MRV1_DMEM_BRIDGE_ALIGN_CHK_EN
    base = issue_cnt;
    req(32'h2, 1'b1, 4'b1111, 32'h1111_2222, 1'b0, 32'h0, 1'b1);
    wait_drain(6);
    req(32'h2, 1'b1, 4'b1100, 32'h3333_4444, 1'b1, 32'h7777_0000, 1'b1);
    wait_issues(base + 1, 10);
    respond(32'h7777_0000);
    wait_drain(5);
`endif

    repeat (5) begin @(posedge clk); #1; end
    chk("mem_queue_empty", exp_mem.size(), 0);
    chk("resp_queue_empty", exp_resp.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
